// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared fixed-point constants and width helpers
package fx_pkg;

  localparam int FX_DEF_IN_W      = 12;
  localparam int FX_DEF_IN_FRAC   = 8;
  localparam int FX_DEF_ACC_W     = 16;
  localparam int FX_DEF_OUT_W     = 12;
  localparam int FX_DEF_OUT_FRAC  = 6;
  localparam int FX_DEF_FRAME_LEN = 64;

  function automatic int fx_sh(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  localparam int FX_DEF_SH = fx_sh(FX_DEF_IN_FRAC, FX_DEF_OUT_FRAC);

  function automatic longint fx_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint fx_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fx_integrator_if.sv
// rtl/fx_integrator_if.sv - sample stream in, requantised running sum out
interface fx_integrator_if import fx_pkg::*; #(
  parameter int IN_W  = FX_DEF_IN_W,
  parameter int OUT_W = FX_DEF_OUT_W
) ();

  logic                    i_valid;
  logic signed [IN_W-1:0]  i_data;
  logic                    i_clear;
  logic                    o_valid;
  logic signed [OUT_W-1:0] o_data;
  logic                    o_last;
  logic                    o_sat;

  modport master (
    output i_valid, i_data, i_clear,
    input  o_valid, o_data, o_last, o_sat
  );

  modport slave (
    input  i_valid, i_data, i_clear,
    output o_valid, o_data, o_last, o_sat
  );

endinterface

// File: rtl/fx_sat.sv
// rtl/fx_sat.sv - generic signed clamp from IN_W to OUT_W bits with clamp flag
module fx_sat import fx_pkg::*; #(
  parameter int IN_W  = FX_DEF_ACC_W + 1,
  parameter int OUT_W = FX_DEF_ACC_W
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    clamp_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(fx_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(fx_min(OUT_W));

  always_comb begin
    dout_o  = din_i[OUT_W-1:0];
    clamp_o = 1'b0;
    if (din_i > MAX_V) begin
      dout_o  = MAX_V[OUT_W-1:0];
      clamp_o = 1'b1;
    end else if (din_i < MIN_V) begin
      dout_o  = MIN_V[OUT_W-1:0];
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/fx_integrator.sv
// rtl/fx_integrator.sv - framed saturating running-sum integrator, 2-stage pipeline
// FX_INTEG_ROUND_EN selects round-half-up requantisation instead of truncation.
module fx_integrator import fx_pkg::*; #(
  parameter int IN_W      = FX_DEF_IN_W,
  parameter int IN_FRAC   = FX_DEF_IN_FRAC,
  parameter int ACC_W     = FX_DEF_ACC_W,
  parameter int OUT_W     = FX_DEF_OUT_W,
  parameter int OUT_FRAC  = FX_DEF_OUT_FRAC,
  parameter int FRAME_LEN = FX_DEF_FRAME_LEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fx_integrator_if.slave  bus
);

  localparam int SH    = fx_sh(IN_FRAC, OUT_FRAC);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d, base;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_base;
  logic                    v1_q, last1_q, sat_q, sat_d, last_d;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    acc_clamp;

  logic                    o_valid_q, o_last_q;
  logic signed [OUT_W-1:0] o_data_q;
  logic signed [ACC_W:0]   acc_x, rq;
  logic signed [OUT_W-1:0] out_sat;
  logic                    out_clamp;

  // cnt_q==0 means a frame just closed (or nothing accepted yet), so restart from 0.
  always_comb begin
    cnt_base = bus.i_clear ? '0 : cnt_q;
    base     = (bus.i_clear || (cnt_q == '0)) ? '0 : acc_q;
    sum      = $signed({base[ACC_W-1], base})
             + $signed({{(ACC_W + 1 - IN_W){bus.i_data[IN_W-1]}}, bus.i_data});
    last_d   = (cnt_base == CNT_LAST);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    if (bus.i_valid) begin
      acc_d = acc_sat;
      cnt_d = last_d ? '0 : cnt_base + CNT_W'(1);
      sat_d = (sat_q && !bus.i_clear) || acc_clamp;
    end else if (bus.i_clear) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  fx_sat #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_sat (
    .din_i   (sum),
    .dout_o  (acc_sat),
    .clamp_o (acc_clamp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      v1_q    <= bus.i_valid;
      last1_q <= bus.i_valid && last_d;
    end
  end

  // One guard bit lets the rounding offset be added without wrapping.
  assign acc_x = $signed({acc_q[ACC_W-1], acc_q});

  generate
    if (SH == 0) begin : g_pass
      assign rq = acc_x;
    end else begin : g_shift
`ifdef FX_INTEG_ROUND_EN
      localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (SH - 1);
      assign rq = (acc_x + HALF) >>> SH;
`else
      assign rq = acc_x >>> SH;
`endif
    end
  endgenerate

  fx_sat #(.IN_W(ACC_W + 1), .OUT_W(OUT_W)) u_out_sat (
    .din_i   (rq),
    .dout_o  (out_sat),
    .clamp_o (out_clamp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      o_valid_q <= v1_q;
      o_last_q  <= last1_q;
      if (v1_q) begin
        o_data_q <= out_sat;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_sat   = sat_q;

  logic unused_out_clamp;
  assign unused_out_clamp = out_clamp;

endmodule

// File: tb/tb_fx_integrator.sv
// tb/tb_fx_integrator.sv - directed self-checking bench for fx_integrator
module tb_fx_integrator;

  logic clk = 1'b0;
  logic rst_n;
  logic valid, clear;
  logic [11:0] data;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fx_integrator_if #(.IN_W(12), .OUT_W(12)) bus  ();
  fx_integrator_if #(.IN_W(12), .OUT_W(12)) bus4 ();

  assign bus.i_valid  = valid;
  assign bus.i_data   = data;
  assign bus.i_clear  = clear;
  assign bus4.i_valid = valid;
  assign bus4.i_data  = data;
  assign bus4.i_clear = clear;

  fx_integrator dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  fx_integrator #(.FRAME_LEN(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic c);
    valid = v;
    data  = d;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_d [5];
    int exp_l [5];
    exp_d = '{64, 128, 192, 256, 64};
    exp_l = '{0, 0, 0, 1, 0};
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_data", $signed(bus.o_data), 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_sat", bus.o_sat, 0);
    rst_n = 1'b1;

    // unit step
    step(1, 12'h100, 0);
    chk("step_lat", bus.o_valid, 0);
    step(1, 12'h100, 0);
    chk("step_v1", bus.o_valid, 1);
    chk("step_d1", $signed(bus.o_data), 64);
    chk("step_l1", bus.o_last, 0);
    step(1, 12'h100, 0);
    chk("step_d2", $signed(bus.o_data), 128);
    step(0, 12'h000, 0);
    chk("step_d3", $signed(bus.o_data), 192);
    chk("step_sat", bus.o_sat, 0);
    step(0, 12'h000, 0);
    chk("step_idle_v", bus.o_valid, 0);
    chk("step_hold_d", $signed(bus.o_data), 192);
    chk("step_idle_l", bus.o_last, 0);

    // frame wrap on the FRAME_LEN=4 instance
    step(0, 12'h000, 1);
    step(1, 12'h100, 0);
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? 1'b1 : 1'b0, 12'h100, 0);
      chk($sformatf("wrap_d%0d", i), $signed(bus4.o_data), exp_d[i]);
      chk($sformatf("wrap_l%0d", i), bus4.o_last, exp_l[i]);
    end

    // saturation
    step(0, 12'h000, 1);
    for (int n = 1; n <= 20; n++) begin
      step(1, 12'h7FF, 0);
`ifdef FX_INTEG_ROUND_EN
      if (n == 2) chk("sat_out1", $signed(bus.o_data), 512);
`else
      if (n == 2) chk("sat_out1", $signed(bus.o_data), 511);
`endif
      if (n == 5)  chk("sat_out4", $signed(bus.o_data), 2047);
      if (n == 6)  chk("sat_out5", $signed(bus.o_data), 2047);
      if (n == 16) chk("sat_flag16", bus.o_sat, 0);
      if (n == 17) chk("sat_flag17", bus.o_sat, 1);
      if (n == 17) chk("sat_out16", $signed(bus.o_data), 2047);
    end
    step(0, 12'h000, 0);
    chk("sat_out20", $signed(bus.o_data), 2047);
    chk("sat_sticky", bus.o_sat, 1);
    step(0, 12'h000, 1);
    chk("sat_clear", bus.o_sat, 0);

    // rounding
    step(1, 12'h002, 0);
    step(0, 12'h000, 1);
`ifdef FX_INTEG_ROUND_EN
    chk("rnd_pos", $signed(bus.o_data), 1);
`else
    chk("rnd_pos", $signed(bus.o_data), 0);
`endif
    step(1, 12'hFFE, 0);
    step(0, 12'h000, 0);
`ifdef FX_INTEG_ROUND_EN
    chk("rnd_neg", $signed(bus.o_data), 0);
`else
    chk("rnd_neg", $signed(bus.o_data), -1);
`endif

    // clear together with a valid sample restarts sum and frame count
    step(0, 12'h000, 1);
    step(1, 12'h100, 0);
    step(1, 12'h100, 0);
    step(1, 12'h100, 1);
    chk("clr_prev", $signed(bus.o_data), 128);
    for (int k = 1; k <= 63; k++) begin
      step(1, 12'h000, 0);
      if (k == 1) begin
        chk("clr_d", $signed(bus.o_data), 64);
        chk("clr_l", bus.o_last, 0);
        chk("clr4_d", $signed(bus4.o_data), 64);
      end
      if (k == 3)  chk("clr4_l2", bus4.o_last, 0);
      if (k == 4)  chk("clr4_l3", bus4.o_last, 1);
      if (k == 63) chk("clr_l62", bus.o_last, 0);
    end
    step(0, 12'h000, 0);
    chk("clr_l63", bus.o_last, 1);
    chk("clr_d63", $signed(bus.o_data), 64);

    // reset while a sample is in flight
    step(1, 12'h100, 0);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus.o_valid, 0);
    chk("mrst_data", $signed(bus.o_data), 0);
    chk("mrst_last", bus.o_last, 0);
    chk("mrst_sat", bus.o_sat, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_hold", bus.o_valid, 0);
    rst_n = 1'b1;
    step(1, 12'h100, 0);
    chk("mrst_lat", bus.o_valid, 0);
    step(0, 12'h000, 0);
    chk("mrst_v", bus.o_valid, 1);
    chk("mrst_d", $signed(bus.o_data), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
